// File: rtl/miner_result_tx_if.sv
// Result-capture and byte-stream signals between the mining controller, the
// result transmitter and the host link.
interface miner_result_tx_if #(
    parameter int unsigned HASH_W  = 256,
    parameter int unsigned NONCE_W = 32
);
    logic               found_valid;
    logic [HASH_W-1:0]  hash_in;
    logic [NONCE_W-1:0] nonce_in;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic [7:0]         drop_count;

    // Controller/host side drives results and ready; observes the stream.
    modport master (
        output found_valid, hash_in, nonce_in, tx_ready,
        input  tx_data, tx_valid, busy, drop_count
    );

    modport slave (
        input  found_valid, hash_in, nonce_in, tx_ready,
        output tx_data, tx_valid, busy, drop_count
    );
endinterface

// File: rtl/miner_result_tx.sv
// Captures one winning {nonce, hash} and serialises it as a SYNC-prefixed byte frame.
// Optional XOR trailer byte enabled by defining MINER_RESULT_CHECKSUM_EN.
module miner_result_tx #(
    parameter int unsigned HASH_W    = 256,
    parameter int unsigned NONCE_W   = 32,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic               clock,
    input  logic               reset,
    miner_result_tx_if.slave   bus
);

    localparam int unsigned PAYLOAD_W     = HASH_W + NONCE_W;
    localparam int unsigned PAYLOAD_BYTES = PAYLOAD_W / 8;
`ifdef MINER_RESULT_CHECKSUM_EN
    localparam int unsigned FRAME_LEN     = PAYLOAD_BYTES + 2;
`else
    localparam int unsigned FRAME_LEN     = PAYLOAD_BYTES + 1;
`endif
    localparam int unsigned IDX_W         = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
`ifdef MINER_RESULT_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_PAYLOAD_IDX = IDX_W'(PAYLOAD_BYTES);
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                state_q,    state_d;
    logic [PAYLOAD_W-1:0]  shreg_q,    shreg_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [7:0]            tx_data_q,  tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q,     busy_d;
    logic [7:0]            drop_q,     drop_d;
`ifdef MINER_RESULT_CHECKSUM_EN
    logic [7:0]            csum_q,     csum_d;
`endif
    logic                  handshake_c;

    assign handshake_c = tx_valid_q & bus.tx_ready;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        drop_d     = drop_q;
`ifdef MINER_RESULT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.found_valid) begin
                    shreg_d    = {bus.nonce_in, bus.hash_in};
                    idx_d      = '0;
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SEND;
`ifdef MINER_RESULT_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                end
            end
            SEND: begin
                // Results arriving mid-frame are counted, never queued.
                if (bus.found_valid && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                if (handshake_c) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        idx_d      = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
`ifdef MINER_RESULT_CHECKSUM_EN
                        // Index 0 is the SYNC byte, which the checksum excludes.
                        if (idx_q != '0) begin
                            csum_d = csum_q ^ tx_data_q;
                        end
                        if (idx_q == LAST_PAYLOAD_IDX) begin
                            tx_data_d = csum_q ^ tx_data_q;
                        end else begin
                            tx_data_d = shreg_q[PAYLOAD_W-1 -: 8];
                            shreg_d   = shreg_q << 8;
                        end
`else
                        tx_data_d = shreg_q[PAYLOAD_W-1 -: 8];
                        shreg_d   = shreg_q << 8;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 8'h00;
`ifdef MINER_RESULT_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
`ifdef MINER_RESULT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.busy       = busy_q;
    assign bus.drop_count = drop_q;

endmodule
